// File: rtl/hilo_ctrl.sv
// ============================================================================
// hilo_ctrl
// ----------------------------------------------------------------------------
// Sequencer and HI/LO register pair that sits downstream of the restoring
// divider. It accepts DIV / DIVU / MTHI / MTLO requests from the main control
// unit and feeds the divider unsigned operand magnitudes. When the divider
// finishes, it captures the raw remainder and quotient, applies MIPS sign
// correction, and holds the architectural HI/LO values. It also generates the
// stall (busy) and divide-by-zero indications for the control unit.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   reset        synchronous active-high reset
//   op_start     single-cycle request, sampled only while idle
//   op_sel       00 DIV (signed), 01 DIVU, 10 MTHI, 11 MTLO
//   rs_data      dividend, or the data written by MTHI/MTLO
//   rt_data      divisor
//   div_control  divider enable; high only while the divide is running
//   div_a        registered dividend magnitude to the divider
//   div_b        registered divisor magnitude to the divider
//   div_hi       raw remainder from the divider
//   div_lo       raw quotient from the divider
//   busy         high whenever an operation is in flight
//   done         one-cycle pulse after a HI/LO update or divide-by-zero abort
//   div_zero     one-cycle pulse, coincident with done, on divide by zero
//   hi, lo       architectural HI and LO
// ============================================================================
module hilo_ctrl #(
    parameter int DIV_CYCLES = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_start,
    input  logic [1:0]  op_sel,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        div_control,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(DIV_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic [31:0]   hi_reg, hi_next;
    logic [31:0]   lo_reg, lo_next;
    logic [31:0]   div_a_reg, div_a_next;
    logic [31:0]   div_b_reg, div_b_next;
    logic          qneg_reg, qneg_next;
    logic          rneg_reg, rneg_next;
    logic          done_reg, done_next;
    logic          div_zero_reg, div_zero_next;
    logic          is_signed;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            div_a_reg    <= '0;
            div_b_reg    <= '0;
            qneg_reg     <= 1'b0;
            rneg_reg     <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            div_a_reg    <= div_a_next;
            div_b_reg    <= div_b_next;
            qneg_reg     <= qneg_next;
            rneg_reg     <= rneg_next;
            done_reg     <= done_next;
            div_zero_reg <= div_zero_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        div_a_next    = div_a_reg;
        div_b_next    = div_b_reg;
        qneg_next     = qneg_reg;
        rneg_next     = rneg_reg;
        done_next     = 1'b0;
        div_zero_next = 1'b0;
        is_signed     = (op_sel == OP_DIV);

        case (state_reg)
            ST_IDLE: begin
                if (op_start) begin
                    if (op_sel == OP_MTHI) begin
                        hi_next   = rs_data;
                        done_next = 1'b1;
                    end else if (op_sel == OP_MTLO) begin
                        lo_next   = rs_data;
                        done_next = 1'b1;
                    end else if (rt_data == 32'd0) begin
                        // Abort without ever enabling the divider.
                        done_next     = 1'b1;
                        div_zero_next = 1'b1;
                    end else begin
                        // Two's-complement negate; 0x80000000 maps to itself,
                        // which is the correct unsigned magnitude.
                        div_a_next = (is_signed && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
                        div_b_next = (is_signed && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;
                        qneg_next  = is_signed && (rs_data[31] ^ rt_data[31]);
                        // Remainder takes the sign of the dividend.
                        rneg_next  = is_signed && rs_data[31];
                        count_next = '0;
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                count_next = count_reg + COUNT_ONE;
                if (count_reg == COUNT_LAST) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                // Divider is disabled here but still holds its raw results.
                lo_next    = qneg_reg ? (~div_lo + 32'd1) : div_lo;
                hi_next    = rneg_reg ? (~div_hi + 32'd1) : div_hi;
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign div_control = (state_reg == ST_RUN);
    assign busy        = (state_reg != ST_IDLE);
    assign div_a       = div_a_reg;
    assign div_b       = div_b_reg;
    assign done        = done_reg;
    assign div_zero    = div_zero_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;

endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
Sequencer and HI/LO register pair downstream of the restoring divider. It accepts DIV/DIVU/MTHI/MTLO from the main control unit and drives the divider's control, A and B inputs with unsigned magnitudes. It captures the divider's raw remainder and quotient, applies MIPS sign correction, and holds the architectural HI/LO values. It also provides the stall and divide-by-zero signals the control unit needs.

Parameters:
DIV_CYCLES, 33, number of consecutive cycles div_control must stay high before the divider's Hi/Lo outputs are valid.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous active-high reset
op_start  input  1  single-cycle request; sampled only in IDLE
op_sel  input  2  00 DIV signed, 01 DIVU, 10 MTHI, 11 MTLO
rs_data  input  32  dividend, or data for MTHI/MTLO
rt_data  input  32  divisor
div_control  output  1  enable to divider; high only in RUN
div_a  output  32  registered dividend magnitude to divider
div_b  output  32  registered divisor magnitude to divider
div_hi  input  32  divider raw remainder
div_lo  input  32  divider raw quotient
busy  output  1  high whenever state != IDLE; control unit stalls on it
done  output  1  registered one-cycle pulse after any HI/LO update or divide-by-zero abort
div_zero  output  1  registered one-cycle pulse, coincident with done, on divide by zero
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- Reset (synchronous, any state): state=IDLE; count=0; hi=lo=0; div_a=div_b=0; done=0; div_zero=0; div_control=0. This also aborts an in-flight division, and dropping div_control clears the divider.
- States: IDLE, RUN, FIX. div_control is driven combinationally as (state==RUN).
- IDLE, op_start=1, op_sel=10/11: write rs_data to hi or lo at that edge. Done is high the next cycle. busy is never asserted.
- IDLE, op_start=1, DIV/DIVU, rt_data==0: no RUN. div_control never rises. hi/lo are unchanged. done and div_zero are high the next cycle.
- IDLE, op_start=1, DIV/DIVU, rt_data!=0: latch the operands and go to RUN with count=0.
  - DIVU: div_a=rs_data, div_b=rt_data.
  - DIV: div_a=|rs_data| and div_b=|rt_data| in two's complement; |0x80000000| stays 0x80000000, which is correct as an unsigned value.
  - Also latch qneg = signed and (rs[31] xor rt[31]), and rneg = signed and rs[31].
- RUN: count increments each edge. At the edge where count==DIV_CYCLES-1, go to FIX. div_control is therefore high for exactly DIV_CYCLES edges.
- FIX: div_control=0; div_hi/div_lo hold the raw results.
  - At the FIX edge: lo = qneg ? -div_lo : div_lo; hi = rneg ? -div_hi : div_hi. State returns to IDLE.
  - done is high the following cycle.
- Latency: with the start sampled at edge E0, hi/lo update at edge E0+DIV_CYCLES+1. busy is high for DIV_CYCLES+1 cycles.
- op_start while busy is ignored and not queued. op_sel, rs_data and rt_data are don't-care outside IDLE.
- Overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no exception.
- hi and lo change only at MTHI/MTLO edges, FIX edges, or reset.

Test Plan:
1. Assert reset for 2 cycles mid-sequence -> hi=lo=0, busy=0, div_control=0, done=0.
2. DIVU rs=100, rt=7 -> div_control high exactly 33 cycles, busy 34 cycles; at edge E0+34, lo=14 and hi=2; single done pulse, div_zero=0.
3. DIV rs=0xFFFFFFF9 (-7), rt=2 -> div_a=7, div_b=2; final lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
4. DIV rs=5, rt=0 with hi=0xAAAA0000 preset -> next cycle done=div_zero=1, div_control never high, hi unchanged.
5. MTHI 0xDEADBEEF, then MTLO 0x12345678 on the next cycle -> hi/lo take these values, done pulses each, busy=0. Then start DIVU and pulse op_start with MTLO during RUN -> the pulse is ignored and lo takes the quotient.
6. Start DIVU 0x80000000/1, assert reset at RUN count 10, then release -> IDLE, hi=lo=0. Restart DIVU 0x80000000/1 -> lo=0x80000000, hi=0. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
